// File: rtl/npu_pkg.sv
// Shared NPU definitions: drain sequencer states, default element widths
// and the saturation limits that go with them.
package npu_pkg;

   localparam int NPU_ACC_W = 16;
   localparam int NPU_OUT_W = 8;
   localparam int NPU_PACK  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } drainState_e;

   function automatic int satMax(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int satMin(input int w);
      return -(1 << (w - 1));
   endfunction

   localparam int SAT_MAX = satMax(NPU_OUT_W);
   localparam int SAT_MIN = satMin(NPU_OUT_W);

endpackage

// File: rtl/requant_drain_ctrl_sat.sv
// Signed saturation of a wide value to OUT_W bits; clip flags an element
// that fell outside the representable output range.
module requant_drain_ctrl_sat
   import npu_pkg::*;
#(
   parameter int IN_W  = NPU_ACC_W + 1,
   parameter int OUT_W = NPU_OUT_W
) (
   input  logic signed [IN_W-1:0]  din_i,
   output logic        [OUT_W-1:0] dout_o,
   output logic                    clip_o
);

   localparam logic signed [IN_W-1:0] HI = IN_W'(satMax(OUT_W));
   localparam logic signed [IN_W-1:0] LO = IN_W'(satMin(OUT_W));

   // Out-of-range values pin to the nearest limit.
   always_comb begin
      dout_o = din_i[OUT_W-1:0];
      clip_o = 1'b0;
      if (din_i > HI) begin
         dout_o = HI[OUT_W-1:0];
         clip_o = 1'b1;
      end else if (din_i < LO) begin
         dout_o = LO[OUT_W-1:0];
         clip_o = 1'b1;
      end
   end

endmodule

// File: rtl/requant_drain_ctrl.sv
// Drains a run of accumulator entries through rounding shift and saturation
// and packs the int8 results into output words with valid/ready handshake.
module requant_drain_ctrl
   import npu_pkg::*;
#(
   parameter int ACC_W  = NPU_ACC_W,
   parameter int OUT_W  = NPU_OUT_W,
   parameter int PACK   = NPU_PACK,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [ADDR_W-1:0]       base_i,
   input  logic [ADDR_W:0]         len_i,
   input  logic [3:0]              shift_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    acc_rd_en_o,
   output logic [ADDR_W-1:0]       acc_rd_addr_o,
   input  logic [ACC_W-1:0]        acc_rd_data_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [PACK*OUT_W-1:0]   out_data_o,
   output logic                    out_last_o,
   output logic [15:0]             sat_cnt_o
);

   localparam int FILL_W = $clog2(PACK + 1);
   localparam int CNT_W  = ADDR_W + 1;
   localparam int EXT_W  = ACC_W + 1;

   drainState_e state_q, state_d;

   logic [ADDR_W-1:0]     addr_q;
   logic [CNT_W-1:0]      len_q;
   logic [CNT_W-1:0]      issued_q;
   logic [CNT_W-1:0]      returned_q;
   logic [3:0]            shift_q;
   logic [FILL_W-1:0]     fill_q;
   logic                  inflight_q;
   logic [PACK*OUT_W-1:0] pack_q;
   logic [PACK*OUT_W-1:0] outData_q;
   logic                  outValid_q;
   logic                  outLast_q;
   logic [15:0]           satCnt_q;

   logic startAccept;
   logic rdEn;
   logic busy;
   logic done;
   logic lastReturned;
   logic packFull;
   logic outFree;
   logic xfer;
   logic lastAccept;

   logic signed [EXT_W-1:0] accExt;
   logic signed [EXT_W-1:0] rndAdd;
   logic signed [EXT_W-1:0] rndSum;
   logic signed [EXT_W-1:0] shifted;
   logic        [OUT_W-1:0] satData;
   logic                    satClip;

   assign startAccept  = start_i && (state_q == IDLE);
   assign lastReturned = (returned_q == len_q);
   assign packFull     = (fill_q == FILL_W'(PACK));
   assign outFree      = !outValid_q || out_ready_i;
   assign xfer         = (packFull || (lastReturned && (fill_q != '0))) && outFree;
   assign lastAccept   = outValid_q && out_ready_i && outLast_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : RUN;
         RUN:     if (issued_q == len_q) state_d = DRAIN;
         DRAIN:   if ((fill_q == '0) && !inflight_q && lastAccept) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A read is only issued when its return is guaranteed a free lane in P.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      rdEn = 1'b0;
      case (state_q)
         RUN: begin
            busy = 1'b1;
            rdEn = (issued_q < len_q) && ((32'(fill_q) + 32'(inflight_q)) < PACK);
         end
         DRAIN:   busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign accExt  = {acc_rd_data_i[ACC_W-1], acc_rd_data_i};
   assign rndAdd  = (shift_q == 4'd0) ? '0 : (EXT_W'(1) << (shift_q - 4'd1));
   assign rndSum  = accExt + rndAdd;
   assign shifted = rndSum >>> shift_q;

   requant_drain_ctrl_sat #(
      .IN_W  (EXT_W),
      .OUT_W (OUT_W)
   ) u_sat (
      .din_i  (shifted),
      .dout_o (satData),
      .clip_o (satClip)
   );

   // A return and a P->O transfer never share a cycle: a full P implies no
   // read in flight, and the tail case implies every element has returned.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         returned_q <= '0;
         shift_q    <= '0;
         fill_q     <= '0;
         inflight_q <= 1'b0;
         pack_q     <= '0;
         satCnt_q   <= '0;
      end else if (startAccept) begin
         addr_q     <= base_i;
         len_q      <= len_i;
         shift_q    <= shift_i;
         issued_q   <= '0;
         returned_q <= '0;
         fill_q     <= '0;
         inflight_q <= 1'b0;
         pack_q     <= '0;
         satCnt_q   <= '0;
      end else begin
         inflight_q <= rdEn;
         if (rdEn) begin
            addr_q   <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
            issued_q <= issued_q + 1'b1;
         end
         if (inflight_q) begin
            for (int i = 0; i < PACK; i++) begin
               if (32'(fill_q) == i) pack_q[i*OUT_W +: OUT_W] <= satData;
            end
            fill_q     <= fill_q + 1'b1;
            returned_q <= returned_q + 1'b1;
            if (satClip && (satCnt_q != 16'hFFFF)) satCnt_q <= satCnt_q + 1'b1;
         end else if (xfer) begin
            pack_q <= '0;
            fill_q <= '0;
         end
      end
   end

   // P is cleared on every transfer, so unwritten tail lanes leave as zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outData_q  <= '0;
         outValid_q <= 1'b0;
         outLast_q  <= 1'b0;
      end else if (xfer) begin
         outData_q  <= pack_q;
         outValid_q <= 1'b1;
         outLast_q  <= lastReturned;
      end else if (outValid_q && out_ready_i) begin
         outValid_q <= 1'b0;
         outLast_q  <= 1'b0;
      end
   end

   assign busy_o        = busy;
   assign done_o        = done;
   assign acc_rd_en_o   = rdEn;
   assign acc_rd_addr_o = addr_q;
   assign out_valid_o   = outValid_q;
   assign out_data_o    = outData_q;
   assign out_last_o    = outLast_q;
   assign sat_cnt_o     = satCnt_q;

endmodule

// File: tb/tb_requant_drain_ctrl.sv
// Directed bench for requant_drain_ctrl: behavioural accumulator memory,
// output word monitor and hand-computed expected words.
module tb_requant_drain_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  base;
   logic [6:0]  len;
   logic [3:0]  shift;
   logic        busy;
   logic        done;
   logic        accRdEn;
   logic [5:0]  accRdAddr;
   logic [15:0] accRdData = '0;
   logic        outValid;
   logic        outReady;
   logic [31:0] outData;
   logic        outLast;
   logic [15:0] satCnt;

   logic [15:0] mem [64];
   int          readCnt;
   logic [5:0]  addrQ [$];
   logic [31:0] wordQ [$];
   logic        lastQ [$];
   logic        validSeen;

   int assertCnt = 0;
   int failCnt   = 0;

   requant_drain_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .base_i        (base),
      .len_i         (len),
      .shift_i       (shift),
      .busy_o        (busy),
      .done_o        (done),
      .acc_rd_en_o   (accRdEn),
      .acc_rd_addr_o (accRdAddr),
      .acc_rd_data_i (accRdData),
      .out_valid_o   (outValid),
      .out_ready_i   (outReady),
      .out_data_o    (outData),
      .out_last_o    (outLast),
      .sat_cnt_o     (satCnt)
   );

   always #5 clk = ~clk;

   // Accumulator buffer with one-cycle read latency, plus the output monitor.
   always @(posedge clk) begin
      if (accRdEn) begin
         accRdData <= mem[accRdAddr];
         readCnt = readCnt + 1;
         addrQ.push_back(accRdAddr);
      end
      if (outValid && outReady) begin
         wordQ.push_back(outData);
         lastQ.push_back(outLast);
      end
      if (outValid) validSeen = 1'b1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clearMonitor();
      readCnt   = 0;
      validSeen = 1'b0;
      addrQ.delete();
      wordQ.delete();
      lastQ.delete();
   endtask

   task automatic applyStimulus(input logic [5:0] b, input logic [6:0] l, input logic [3:0] s);
      @(negedge clk);
      base  = b;
      len   = l;
      shift = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n = 0;
      while ((done !== 1'b1) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, {31'b0, done}, 32'd1);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      base     = '0;
      len      = '0;
      shift    = '0;
      outReady = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = 16'(i);
      clearMonitor();

      repeat (3) @(negedge clk);
      checkOutput("reset_busy",  {31'b0, busy},     32'd0);
      checkOutput("reset_done",  {31'b0, done},     32'd0);
      checkOutput("reset_rden",  {31'b0, accRdEn},  32'd0);
      checkOutput("reset_valid", {31'b0, outValid}, 32'd0);
      checkOutput("reset_last",  {31'b0, outLast},  32'd0);
      checkOutput("reset_data",  outData,           32'd0);
      checkOutput("reset_addr",  {26'b0, accRdAddr}, 32'd0);
      checkOutput("reset_sat",   {16'b0, satCnt},   32'd0);
      rst = 1'b0;

      // Plain clip
      mem[0] = 16'd100; mem[1] = -16'sd200; mem[2] = 16'd127; mem[3] = -16'sd128;
      clearMonitor();
      applyStimulus(6'd0, 7'd4, 4'd0);
      waitDone("clip_done", 60);
      checkOutput("clip_busy_in_done", {31'b0, busy}, 32'd1);
      checkOutput("clip_words", 32'(wordQ.size()), 32'd1);
      checkOutput("clip_word0", wordQ[0], 32'h807F8064);
      checkOutput("clip_last0", {31'b0, lastQ[0]}, 32'd1);
      checkOutput("clip_sat", {16'b0, satCnt}, 32'd1);
      @(negedge clk);
      checkOutput("clip_done_pulse", {31'b0, done}, 32'd0);
      checkOutput("clip_idle_busy", {31'b0, busy}, 32'd0);

      // Rounding shift
      mem[8] = 16'd6; mem[9] = -16'sd6; mem[10] = 16'd5; mem[11] = 16'd32767;
      clearMonitor();
      applyStimulus(6'd8, 7'd4, 4'd2);
      waitDone("rnd_done", 60);
      checkOutput("rnd_words", 32'(wordQ.size()), 32'd1);
      checkOutput("rnd_word0", wordQ[0], 32'h7F01FF02);
      checkOutput("rnd_sat", {16'b0, satCnt}, 32'd1);

      // Backpressure
      for (int i = 0; i < 8; i++) mem[16+i] = 16'(i + 1);
      clearMonitor();
      outReady = 1'b0;
      applyStimulus(6'd16, 7'd8, 4'd0);
      repeat (7) @(negedge clk);
      checkOutput("bp_valid_mid", {31'b0, outValid}, 32'd1);
      checkOutput("bp_data_mid", outData, 32'h04030201);
      repeat (4) @(negedge clk);
      checkOutput("bp_data_held", outData, 32'h04030201);
      checkOutput("bp_last_held", {31'b0, outLast}, 32'd0);
      checkOutput("bp_rden_stalled", {31'b0, accRdEn}, 32'd0);
      checkOutput("bp_reads_stalled", 32'(readCnt), 32'd8);
      outReady = 1'b1;
      waitDone("bp_done", 60);
      checkOutput("bp_words", 32'(wordQ.size()), 32'd2);
      checkOutput("bp_word0", wordQ[0], 32'h04030201);
      checkOutput("bp_last0", {31'b0, lastQ[0]}, 32'd0);
      checkOutput("bp_word1", wordQ[1], 32'h08070605);
      checkOutput("bp_last1", {31'b0, lastQ[1]}, 32'd1);
      checkOutput("bp_reads", 32'(readCnt), 32'd8);

      // Tail padding
      for (int i = 0; i < 5; i++) mem[24+i] = 16'(i + 1);
      clearMonitor();
      applyStimulus(6'd24, 7'd5, 4'd0);
      waitDone("tail_done", 60);
      checkOutput("tail_words", 32'(wordQ.size()), 32'd2);
      checkOutput("tail_word0", wordQ[0], 32'h04030201);
      checkOutput("tail_last0", {31'b0, lastQ[0]}, 32'd0);
      checkOutput("tail_word1", wordQ[1], 32'h00000005);
      checkOutput("tail_last1", {31'b0, lastQ[1]}, 32'd1);

      // Zero length
      clearMonitor();
      applyStimulus(6'd3, 7'd0, 4'd0);
      checkOutput("zero_done", {31'b0, done}, 32'd1);
      checkOutput("zero_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      checkOutput("zero_done_pulse", {31'b0, done}, 32'd0);
      checkOutput("zero_busy_after", {31'b0, busy}, 32'd0);
      checkOutput("zero_no_valid", {31'b0, validSeen}, 32'd0);
      checkOutput("zero_reads", 32'(readCnt), 32'd0);

      // Address wrap with an ignored start while busy
      mem[62] = 16'd500; mem[63] = 16'h0022; mem[0] = 16'h0033; mem[1] = 16'h0044;
      clearMonitor();
      applyStimulus(6'd62, 7'd4, 4'd0);
      @(negedge clk);
      @(negedge clk);
      base  = 6'd5;
      len   = 7'd2;
      shift = 4'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone("wrap_done", 60);
      checkOutput("wrap_reads", 32'(readCnt), 32'd4);
      checkOutput("wrap_addr0", {26'b0, addrQ[0]}, 32'd62);
      checkOutput("wrap_addr1", {26'b0, addrQ[1]}, 32'd63);
      checkOutput("wrap_addr2", {26'b0, addrQ[2]}, 32'd0);
      checkOutput("wrap_addr3", {26'b0, addrQ[3]}, 32'd1);
      checkOutput("wrap_words", 32'(wordQ.size()), 32'd1);
      checkOutput("wrap_word0", wordQ[0], 32'h4433227F);
      checkOutput("wrap_sat", {16'b0, satCnt}, 32'd1);

      // Reset in the middle of RUN
      mem[40] = 16'd1000; mem[41] = 16'd2; mem[42] = 16'd3; mem[43] = 16'd4;
      clearMonitor();
      applyStimulus(6'd40, 7'd8, 4'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_reads", 32'(readCnt), 32'd2);
      checkOutput("mid_busy",  {31'b0, busy},      32'd0);
      checkOutput("mid_done",  {31'b0, done},      32'd0);
      checkOutput("mid_rden",  {31'b0, accRdEn},   32'd0);
      checkOutput("mid_valid", {31'b0, outValid},  32'd0);
      checkOutput("mid_data",  outData,            32'd0);
      checkOutput("mid_addr",  {26'b0, accRdAddr}, 32'd0);
      checkOutput("mid_sat",   {16'b0, satCnt},    32'd0);
      rst = 1'b0;
      clearMonitor();
      applyStimulus(6'd40, 7'd4, 4'd0);
      waitDone("post_done", 60);
      checkOutput("post_reads", 32'(readCnt), 32'd4);
      checkOutput("post_words", 32'(wordQ.size()), 32'd1);
      checkOutput("post_word0", wordQ[0], 32'h0403027F);
      checkOutput("post_last0", {31'b0, lastQ[0]}, 32'd1);
      checkOutput("post_sat", {16'b0, satCnt}, 32'd1);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
